// File: rtl/movement_controller_pkg.sv
// Shared definitions for the sprite movement controller and its datapath.
// State codes double as the datapath control word.
package movement_pkg;

  typedef enum logic [3:0] {
    ST_HOLD    = 4'b0000,
    ST_CLEAR   = 4'b0001,
    ST_RIGHT   = 4'b0010,
    ST_LEFT    = 4'b0011,
    ST_PREHOLD = 4'b0100,
    ST_DRAW    = 4'b0101,
    ST_DOWN    = 4'b0110,
    ST_UP      = 4'b0111
  } state_e;

  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;
  localparam int SPRITE_PIXELS = 16;

  // Opposing keys cancel; ST_HOLD doubles as "no step on this axis".
  function automatic state_e h_dir(input logic left, input logic right);
    if (right && !left) return ST_RIGHT;
    if (left && !right) return ST_LEFT;
    return ST_HOLD;
  endfunction

  function automatic state_e v_dir(input logic up, input logic down);
    if (down && !up) return ST_DOWN;
    if (up && !down) return ST_UP;
    return ST_HOLD;
  endfunction

endpackage

// File: rtl/movement_controller_if.sv
// Key / datapath handshake bundle for the movement controller.
// master = controller side, slave = key synchroniser + datapath side.
interface movement_controller_if;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       draw_done;
  logic [3:0] control;
  logic       busy;
  logic       frame_tick;
  logic       timeout_err;

  modport master (
    input  key_left, key_right, key_up, key_down, draw_done,
    output control, busy, frame_tick, timeout_err
  );

  modport slave (
    output key_left, key_right, key_up, key_down, draw_done,
    input  control, busy, frame_tick, timeout_err
  );
endinterface

// File: rtl/movement_controller_frame_tick_gen.sv
// Free-running divider: tick_o is high during the cycle the counter wraps
// (count == TICK_DIV-1), once every TICK_DIV cycles. TICK_DIV must be >= 2.
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;
  logic          tick_q;
  logic          wrap;

  assign wrap   = (cnt_q == CW'(TICK_DIV - 1));
  assign tick_o = tick_q;

  // Tick is registered one count early so it lines up with the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
      tick_q <= (cnt_q == CW'(TICK_DIV - 2));
    end
  end
endmodule

// File: rtl/movement_controller.sv
// Sprite movement sequencer: erase, step X then Y, redraw on each frame tick.
// Optional WATCHDOG_EN bounds the CLEAR/DRAW wait and flags timeout_err.
module movement_controller
  import movement_pkg::*;
#(
  parameter int TICK_DIV = 833333
`ifdef WATCHDOG_EN
  , parameter int DONE_TIMEOUT = 64
`endif
) (
  input logic                  clk,
  input logic                  reset,
  movement_controller_if.master bus
);
  state_e state_q, state_d;
  state_e h_q, h_d, v_q, v_d;
  logic   busy_q;
  logic   tick_w;
  logic   done_w;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (reset),
    .tick_o(tick_w)
  );

`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(DONE_TIMEOUT + 1);
  logic [WDW-1:0] wd_q;
  logic           err_q;
  logic           waiting;
  logic           wd_fire;

  assign waiting = (state_q == ST_CLEAR) || (state_q == ST_DRAW);
  assign wd_fire = waiting && (wd_q == WDW'(DONE_TIMEOUT - 1));
  assign done_w  = bus.draw_done | wd_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q) wd_q <= '0;
      else if (waiting)       wd_q <= wd_q + WDW'(1);
      if (wd_fire && !bus.draw_done) err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign done_w          = bus.draw_done;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      ST_PREHOLD: state_d = ST_DRAW;
      ST_HOLD: if (tick_w) begin
        h_d = h_dir(bus.key_left, bus.key_right);
        v_d = v_dir(bus.key_up, bus.key_down);
        if (h_d != ST_HOLD || v_d != ST_HOLD) state_d = ST_CLEAR;
      end
      ST_CLEAR: if (done_w) state_d = (h_q != ST_HOLD) ? h_q : v_q;
      ST_LEFT, ST_RIGHT: state_d = (v_q != ST_HOLD) ? v_q : ST_DRAW;
      ST_UP, ST_DOWN:    state_d = ST_DRAW;
      ST_DRAW: if (done_w) state_d = ST_HOLD;
      default: state_d = ST_PREHOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PREHOLD;
      h_q     <= ST_HOLD;
      v_q     <= ST_HOLD;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      busy_q  <= (state_d != ST_HOLD);
    end
  end

  assign bus.control    = state_q;
  assign bus.busy       = busy_q;
  assign bus.frame_tick = tick_w;
endmodule

// File: tb/tb_movement_controller.sv
// Scoreboard bench for movement_controller (TICK_DIV=8; DONE_TIMEOUT=4 under WATCHDOG_EN).
// Stimulus queues expected control codes; a negedge monitor checks every change.
module tb_movement_controller;
  localparam logic [3:0] C_HOLD = 4'b0000, C_CLEAR = 4'b0001, C_RIGHT = 4'b0010,
                         C_LEFT = 4'b0011, C_PRE = 4'b0100, C_DRAW = 4'b0101,
                         C_DOWN = 4'b0110, C_UP = 4'b0111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  movement_controller_if bus();

  movement_controller #(
    .TICK_DIV(8)
`ifdef WATCHDOG_EN
    , .DONE_TIMEOUT(4)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every control change must match the next queued code; step states last 1 cycle.
  logic [3:0] prev = C_PRE;
  int run = 0;
  always @(negedge clk) begin
    if (bus.control !== prev) begin
      if (prev inside {C_LEFT, C_RIGHT, C_UP, C_DOWN}) chk("step_len", run, 1);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ctrl: got %b, want no change", bus.control);
      end else begin
        chk("ctrl_seq", bus.control, exp_q.pop_front());
      end
      prev <= bus.control;
      run  <= 1;
    end else begin
      run <= run + 1;
    end
  end

  task automatic wait_ctrl(input logic [3:0] c, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.control === c) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got control %b, want %b within 40 cycles", nm, bus.control, c);
    end
  endtask

  task automatic wait_ft(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no frame_tick, want one within 20 cycles", nm);
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 bus.draw_done = 1'b1;
    @(posedge clk); #1 bus.draw_done = 1'b0;
  endtask

  task automatic push4(input logic [3:0] a, b, c, d);
    exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, want finish before 100us");
    $fatal(1);
  end

  initial begin
    int gap;
    int dl;
    bus.key_left = 1'b0; bus.key_right = 1'b0; bus.key_up = 1'b0; bus.key_down = 1'b0;
    bus.draw_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_control", bus.control, C_PRE);
    chk("rst_busy", bus.busy, 1);
    chk("rst_tick", bus.frame_tick, 0);
    chk("rst_err", bus.timeout_err, 0);

    // Initial paint
    exp_q.push_back(C_DRAW);
    @(posedge clk); #1 reset = 1'b0;
    wait_ctrl(C_DRAW, "prehold_to_draw");
    chk("draw_busy", bus.busy, 1);
`ifndef WATCHDOG_EN
    repeat (15) @(negedge clk);
    chk("draw_waits", bus.control, C_DRAW);
    chk("no_wd_err", bus.timeout_err, 0);
`endif
    exp_q.push_back(C_HOLD);
    pulse_done();
    wait_ctrl(C_HOLD, "draw_to_hold");
    chk("hold_busy", bus.busy, 0);

    // Tick period and width, idle keys keep HOLD
    wait_ft("tick_first");
    gap = 0;
    do begin @(negedge clk); gap++; end while (bus.frame_tick !== 1'b1 && gap < 20);
    chk("tick_period", gap, 8);
    @(negedge clk);
    chk("tick_width", bus.frame_tick, 0);

    // Right move; key released mid-sequence
    bus.key_right = 1'b1;
    push4(C_CLEAR, C_RIGHT, C_DRAW, C_HOLD);
    wait_ctrl(C_CLEAR, "right_clear");
    bus.key_right = 1'b0;
    pulse_done();
    wait_ctrl(C_DRAW, "right_draw");
    pulse_done();
    wait_ctrl(C_HOLD, "right_hold");

    // Diagonal left+up
    bus.key_left = 1'b1; bus.key_up = 1'b1;
    push4(C_CLEAR, C_LEFT, C_UP, C_DRAW);
    exp_q.push_back(C_HOLD);
    wait_ctrl(C_CLEAR, "diag_clear");
    bus.key_left = 1'b0; bus.key_up = 1'b0;
    pulse_done();
    wait_ctrl(C_DRAW, "diag_draw");
    pulse_done();
    wait_ctrl(C_HOLD, "diag_hold");

    // Opposing horizontal keys cancel
    bus.key_left = 1'b1; bus.key_right = 1'b1;
    wait_ft("cancel_tick1");
    wait_ft("cancel_tick2");
    @(negedge clk);
    chk("cancel_ctrl", bus.control, C_HOLD);
    chk("cancel_busy", bus.busy, 0);
    bus.key_left = 1'b0; bus.key_right = 1'b0;

    // Down released during CLEAR still executes DOWN
    bus.key_down = 1'b1;
    push4(C_CLEAR, C_DOWN, C_DRAW, C_HOLD);
    wait_ctrl(C_CLEAR, "down_clear");
    bus.key_down = 1'b0;
    pulse_done();
    wait_ctrl(C_DRAW, "down_draw");
    pulse_done();
    wait_ctrl(C_HOLD, "down_hold");

    // Stray draw_done in HOLD
    pulse_done();
    repeat (3) @(negedge clk);
    chk("stray_done", bus.control, C_HOLD);

`ifndef WATCHDOG_EN
    // Tick during DRAW is dropped
    bus.key_right = 1'b1;
    exp_q.push_back(C_CLEAR); exp_q.push_back(C_RIGHT); exp_q.push_back(C_DRAW);
    wait_ctrl(C_CLEAR, "tdraw_clear");
    pulse_done();
    wait_ctrl(C_DRAW, "tdraw_draw");
    wait_ft("tdraw_tick");
    chk("tick_in_draw", bus.control, C_DRAW);
    exp_q.push_back(C_HOLD);
    pulse_done();
    wait_ctrl(C_HOLD, "tdraw_hold");
    repeat (3) @(negedge clk);
    chk("tick_not_queued", bus.control, C_HOLD);
    push4(C_CLEAR, C_RIGHT, C_DRAW, C_HOLD);
    wait_ctrl(C_CLEAR, "tdraw_next_clear");
    bus.key_right = 1'b0;
    pulse_done();
    wait_ctrl(C_DRAW, "tdraw_next_draw");
    pulse_done();
    wait_ctrl(C_HOLD, "tdraw_next_hold");
`else
    // Watchdog: no draw_done at all
    chk("wd_err_before", bus.timeout_err, 0);
    bus.key_up = 1'b1;
    push4(C_CLEAR, C_UP, C_DRAW, C_HOLD);
    wait_ctrl(C_CLEAR, "wd_clear");
    bus.key_up = 1'b0;
    wait_ctrl(C_DRAW, "wd_draw");
    dl = 1;
    forever begin
      @(negedge clk);
      if (bus.control !== C_DRAW || dl >= 20) break;
      dl++;
    end
    chk("wd_draw_len", dl, 4);
    chk("wd_err_set", bus.timeout_err, 1);
    bus.key_right = 1'b1;
    push4(C_CLEAR, C_RIGHT, C_DRAW, C_HOLD);
    wait_ctrl(C_CLEAR, "wd_next_clear");
    bus.key_right = 1'b0;
    pulse_done();
    wait_ctrl(C_DRAW, "wd_next_draw");
    pulse_done();
    wait_ctrl(C_HOLD, "wd_next_hold");
    chk("wd_err_sticky", bus.timeout_err, 1);
`endif

    // Reset mid-sequence
    bus.key_right = 1'b1;
    exp_q.push_back(C_CLEAR);
    wait_ctrl(C_CLEAR, "midrst_clear");
    exp_q.push_back(C_PRE);
    #1 reset = 1'b1;
    bus.key_right = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_ctrl", bus.control, C_PRE);
    chk("midrst_busy", bus.busy, 1);
    chk("midrst_err", bus.timeout_err, 0);
    chk("midrst_tick", bus.frame_tick, 0);
    exp_q.push_back(C_DRAW);
    @(posedge clk); #1 reset = 1'b0;
    wait_ctrl(C_DRAW, "midrst_draw");
    exp_q.push_back(C_HOLD);
    pulse_done();
    wait_ctrl(C_HOLD, "midrst_hold");

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/movement_controller.md
Name: movement_controller

Overview:
FSM that sequences the sprite movement datapath through its control codes. On each frame tick it samples the direction keys. If any movement is requested, it erases the 4x4 sprite, steps X and/or Y by one, and redraws. The block sits between the key synchroniser and the movement datapath; it drives the datapath's 4-bit control input and consumes its drawing-done pulse.

Parameters:
TICK_DIV, 833333, clock cycles per movement frame (50 MHz / 60 Hz); must be >= 2.
DONE_TIMEOUT, 64, cycles allowed in CLEAR/DRAW before the watchdog fires (used only with WATCHDOG_EN).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_left  input  1  level, synchronised, 1 = pressed
key_right  input  1  level, synchronised
key_up  input  1  level, synchronised
key_down  input  1  level, synchronised
draw_done  input  1  one-cycle pulse from datapath when the 16-pixel draw/erase finishes
control  output  4  datapath state code
busy  output  1  high in every state except HOLD
frame_tick  output  1  one-cycle pulse every TICK_DIV cycles
timeout_err  output  1  sticky watchdog flag (0 when WATCHDOG_EN is undefined)

Behaviour:
- One clock domain; reset is asynchronous and active-high. All outputs are registered.
- Reset values: control=PREHOLD (4'b0100), busy=1, frame_tick=0, timeout_err=0, tick counter=0, latched keys=0.
- State codes, shared with the datapath: PREHOLD=0100, HOLD=0000, CLEAR=0001, LEFT=0011, RIGHT=0010, DOWN=0110, UP=0111, DRAW=0101. control equals the current state.
- Tick counter runs 0..TICK_DIV-1 and wraps. frame_tick pulses in the wrap cycle. The counter free-runs in every state.
- PREHOLD -> DRAW unconditionally after 1 cycle. This is the initial sprite paint.
- HOLD: on frame_tick, latch the keys:
  - h = RIGHT if right&~left; LEFT if left&~right; none otherwise (both pressed cancels).
  - v = DOWN if down&~up; UP if up&~down; none otherwise.
  - If h or v is set -> CLEAR; else stay in HOLD.
- CLEAR: stay until draw_done, then go to h if set, else v.
- LEFT/RIGHT: 1 cycle, then go to v if set, else DRAW.
- UP/DOWN: 1 cycle, then DRAW.
- DRAW: stay until draw_done, then HOLD.
- Move latency for a single direction: CLEAR (n cycles) + 1 + DRAW (m cycles). A diagonal move adds 1 cycle.
- draw_done outside CLEAR/DRAW is ignored. A frame_tick outside HOLD is dropped; it is not queued.
- Keys change only at the latch; mid-sequence key changes are ignored.
- Reset asserted mid-sequence returns to PREHOLD immediately. The datapath sees control=PREHOLD, which is a non-draw code.

Optional Feature:
WATCHDOG_EN
- Defined:
  - A cycle counter clears on entry to CLEAR/DRAW and increments while waiting.
  - When it reaches DONE_TIMEOUT, the FSM proceeds as if draw_done had arrived and sets timeout_err.
  - timeout_err stays high until reset.
- Undefined: no counter is built. timeout_err is tied 0 and CLEAR/DRAW wait indefinitely.

Decomposition:
- Package movement_pkg holds:
  - the state-code localparams/enum (4-bit), shared with the datapath;
  - the screen limits 160/120;
  - SPRITE_PIXELS=16.
- One sub-module, frame_tick_gen: a parameterised TICK_DIV counter producing frame_tick, reusable by other sprites.

Test Plan:
- Reset release, TICK_DIV=8:
  - control goes 0100 -> 0101.
  - Pulse draw_done at cycle 17 -> control 0000, busy=0.
- key_right held, tick:
  - control goes 0000 -> 0001.
  - draw_done -> 0010 for exactly 1 cycle -> 0101.
  - draw_done -> 0000.
- key_left+key_up held: sequence 0001, 0011, 0111, 0101, 0000 (LEFT and UP 1 cycle each).
- key_left+key_right held, no vertical key: tick produces no transition; control stays 0000.
- key_down released during CLEAR: DOWN (0110) still executes.
- Edge cases:
  - A tick during DRAW is not queued.
  - A stray draw_done in HOLD is ignored.
- WATCHDOG_EN, DONE_TIMEOUT=4, draw_done never pulsed:
  - DRAW exits after 4 cycles.
  - timeout_err=1, and it holds through later moves until reset.
